// File: rtl/register_file_flat_reader_pkg.sv
// Shared types and helpers for the flat register file reader and its row counter.
package register_file_flat_reader_pkg;

  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  // A single-row file still needs a one-bit index port.
  function automatic int idx_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/register_file_flat_reader_scan_row_counter.sv
// Row counter for scanning a register file: index, one-hot select and last-row flag,
// all held in flops so consumers see glitch-free selects.
module scan_row_counter
  import register_file_flat_reader_pkg::*;
#(
  parameter int HEIGHT = 3,
  parameter int IDX_W  = idx_width(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              clear,
  output logic [IDX_W-1:0]  row,
  output logic [HEIGHT-1:0] sel,
  output logic              is_last
);

  localparam int LAST_BUT_ONE = (HEIGHT > 1) ? HEIGHT - 2 : 0;
  localparam logic ONE_ROW = (HEIGHT == 1);

  // is_last is precomputed one step ahead so it is valid in the same cycle as row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      sel     <= '0;
      is_last <= 1'b0;
    end else if (clear) begin
      row     <= '0;
      sel     <= '0;
      is_last <= 1'b0;
    end else if (load) begin
      row     <= '0;
      sel     <= HEIGHT'(1);
      is_last <= ONE_ROW;
    end else if (advance && !is_last) begin
      row     <= row + IDX_W'(1);
      sel     <= sel << 1;
      is_last <= (row == IDX_W'(LAST_BUT_ONE));
    end
  end

endmodule

// File: rtl/register_file_flat_reader.sv
// Snapshots a flat HEIGHT*WIDTH register bus on Start and streams it out one row
// per beat over a valid/ready handshake, with index, one-hot select and last flag.
module register_file_flat_reader
  import register_file_flat_reader_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 3,
  parameter int IDX_W  = idx_width(HEIGHT)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [HEIGHT*WIDTH-1:0] In,
  output logic [WIDTH-1:0]        Data,
  output logic [IDX_W-1:0]        Idx,
  output logic [HEIGHT-1:0]       Cs,
  output logic                    Valid,
  input  logic                    Ready,
  output logic                    Last,
  output logic                    Busy,
  output logic                    Done
);

  rd_state_t               state;
  rd_state_t               state_next;
  logic                    load;
  logic                    advance;
  logic                    clear;
  logic                    finish;
  logic [HEIGHT*WIDTH-1:0] snap;
  logic [WIDTH-1:0]        data_q;
  logic                    done_q;
  logic [IDX_W-1:0]        next_row;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only honoured in IDLE, so a request during a scan is simply dropped.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    clear      = 1'b0;
    finish     = 1'b0;
    case (state)
      RD_IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = RD_SEND;
        end
      end
      RD_SEND: begin
        if (Ready) begin
          if (Last) begin
            clear      = 1'b1;
            finish     = 1'b1;
            state_next = RD_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  scan_row_counter #(
    .HEIGHT (HEIGHT),
    .IDX_W  (IDX_W)
  ) u_row_counter (
    .clk     (Clk),
    .rst     (Rst),
    .load    (load),
    .advance (advance),
    .clear   (clear),
    .row     (Idx),
    .sel     (Cs),
    .is_last (Last)
  );

  // Held at the current row on the last beat so the part-select never leaves the bus.
  always_comb begin
    next_row = Last ? Idx : Idx + IDX_W'(1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      snap <= '0;
    end else if (load) begin
      snap <= In;
    end
  end

  // Row 0 comes straight from In on load; later rows come only from the snapshot.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= In[WIDTH-1:0];
    end else if (advance) begin
      data_q <= snap[WIDTH*int'(next_row) +: WIDTH];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
    end
  end

  assign Data  = data_q;
  assign Valid = (state == RD_SEND);
  assign Busy  = (state == RD_SEND);
  assign Done  = done_q;

endmodule

// File: tb/tb_register_file_flat_reader.sv
// Self-checking bench: directed scans with literal expectations plus a long random run
// compared every cycle against a beat-level model of the reader.
module tb_register_file_flat_reader;

  localparam int W = 8;
  localparam int H = 3;

  logic           Clk;
  logic           Rst;
  logic           Start;
  logic [H*W-1:0] In;
  logic [W-1:0]   Data;
  logic [1:0]     Idx;
  logic [H-1:0]   Cs;
  logic           Valid;
  logic           Ready;
  logic           Last;
  logic           Busy;
  logic           Done;

  logic           h1_rst;
  logic           h1_start;
  logic [W-1:0]   h1_in;
  logic [W-1:0]   h1_data;
  logic [0:0]     h1_idx;
  logic [0:0]     h1_cs;
  logic           h1_valid;
  logic           h1_ready;
  logic           h1_last;
  logic           h1_busy;
  logic           h1_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 0;

  bit           m_busy;
  bit           m_done;
  int           m_beat;
  logic [W-1:0] m_rows [H];

  register_file_flat_reader #(.WIDTH(W), .HEIGHT(H)) u_dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In(In), .Data(Data), .Idx(Idx), .Cs(Cs),
    .Valid(Valid), .Ready(Ready), .Last(Last), .Busy(Busy), .Done(Done)
  );

  register_file_flat_reader #(.WIDTH(W), .HEIGHT(1)) u_dut_h1 (
    .Clk(Clk), .Rst(h1_rst), .Start(h1_start), .In(h1_in), .Data(h1_data), .Idx(h1_idx),
    .Cs(h1_cs), .Valid(h1_valid), .Ready(h1_ready), .Last(h1_last), .Busy(h1_busy),
    .Done(h1_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input int i, input logic [2:0] c, input bit l);
    check_output("beat_valid", 32'(Valid), 32'd1);
    check_output("beat_busy", 32'(Busy), 32'd1);
    check_output("beat_data", 32'(Data), 32'(d));
    check_output("beat_idx", 32'(Idx), 32'(i));
    check_output("beat_cs", 32'(Cs), 32'(c));
    check_output("beat_last", 32'(Last), 32'(l));
    check_output("beat_done", 32'(Done), 32'd0);
  endtask

  task automatic expect_idle(input bit done_exp);
    check_output("idle_valid", 32'(Valid), 32'd0);
    check_output("idle_busy", 32'(Busy), 32'd0);
    check_output("idle_cs", 32'(Cs), 32'd0);
    check_output("idle_done", 32'(Done), 32'(done_exp));
  endtask

  task automatic expect_all_zero();
    check_output("rst_valid", 32'(Valid), 32'd0);
    check_output("rst_data", 32'(Data), 32'd0);
    check_output("rst_idx", 32'(Idx), 32'd0);
    check_output("rst_cs", 32'(Cs), 32'd0);
    check_output("rst_last", 32'(Last), 32'd0);
    check_output("rst_busy", 32'(Busy), 32'd0);
    check_output("rst_done", 32'(Done), 32'd0);
  endtask

  task automatic apply_stimulus(input bit start, input bit ready, input logic [H*W-1:0] bus);
    Start = start;
    Ready = ready;
    In    = bus;
  endtask

  // Beat-level model: a scan is "which snapshot, which beat"; a beat ends when accepted.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_busy = 0;
      m_done = 0;
      m_beat = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (Ready) begin
          if (m_beat == H - 1) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_beat = m_beat + 1;
          end
        end
      end else if (Start) begin
        m_busy = 1;
        m_beat = 0;
        for (int i = 0; i < H; i++) m_rows[i] = In[i*W +: W];
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_on) begin
      check_output("cmp_valid", 32'(Valid), 32'(m_busy));
      check_output("cmp_busy", 32'(Busy), 32'(m_busy));
      check_output("cmp_done", 32'(Done), 32'(m_done));
      if (m_busy) begin
        check_output("cmp_data", 32'(Data), 32'(m_rows[m_beat]));
        check_output("cmp_idx", 32'(Idx), 32'(m_beat));
        check_output("cmp_cs", 32'(Cs), 32'd1 << m_beat);
        check_output("cmp_last", 32'(Last), 32'(m_beat == H - 1));
      end else begin
        check_output("cmp_cs_idle", 32'(Cs), 32'd0);
      end
    end
  end

  initial begin
    Rst = 1'b1;
    apply_stimulus(1'b0, 1'b1, '0);
    h1_rst = 1'b1; h1_start = 1'b0; h1_in = '0; h1_ready = 1'b1;
    tick();
    tick();
    expect_all_zero();
    check_output("h1_rst_valid", 32'(h1_valid), 32'd0);
    Rst = 1'b0;
    h1_rst = 1'b0;
    cmp_on = 1;
    tick();

    // Basic scan with Ready tied high.
    apply_stimulus(1'b1, 1'b1, 24'h332211);
    tick(); Start = 1'b0;
    expect_beat(8'h11, 0, 3'b001, 1'b0);
    tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    tick(); expect_beat(8'h33, 2, 3'b100, 1'b1);
    tick(); expect_idle(1'b1);
    tick(); expect_idle(1'b0);

    // Backpressure on beat 1.
    apply_stimulus(1'b1, 1'b1, 24'h332211);
    tick(); Start = 1'b0;
    expect_beat(8'h11, 0, 3'b001, 1'b0);
    tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    Ready = 1'b0;
    repeat (4) begin
      tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    end
    Ready = 1'b1;
    tick(); expect_beat(8'h33, 2, 3'b100, 1'b1);
    tick(); expect_idle(1'b1);
    tick();

    // Coherency: In changes right after the Start edge.
    apply_stimulus(1'b1, 1'b1, 24'h332211);
    tick(); Start = 1'b0; In = 24'hCCBBAA;
    expect_beat(8'h11, 0, 3'b001, 1'b0);
    tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    tick(); expect_beat(8'h33, 2, 3'b100, 1'b1);
    tick(); expect_idle(1'b1);
    tick();

    // Start held through a scan is ignored; Start in the Done cycle launches a new scan.
    apply_stimulus(1'b1, 1'b1, 24'h332211);
    tick(); expect_beat(8'h11, 0, 3'b001, 1'b0);
    tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    tick(); expect_beat(8'h33, 2, 3'b100, 1'b1);
    tick(); expect_idle(1'b1);
    In = 24'h998877;
    tick(); Start = 1'b0;
    expect_beat(8'h77, 0, 3'b001, 1'b0);
    tick(); expect_beat(8'h88, 1, 3'b010, 1'b0);
    tick(); expect_beat(8'h99, 2, 3'b100, 1'b1);
    tick(); expect_idle(1'b1);
    tick(); expect_idle(1'b0);

    // Reset mid-scan aborts at once and suppresses Done.
    apply_stimulus(1'b1, 1'b1, 24'h332211);
    tick(); Start = 1'b0;
    tick(); expect_beat(8'h22, 1, 3'b010, 1'b0);
    #1 Rst = 1'b1;
    #1 expect_all_zero();
    tick(); expect_all_zero();
    Rst = 1'b0;
    tick(); expect_idle(1'b0);
    apply_stimulus(1'b1, 1'b1, 24'h554433);
    tick(); Start = 1'b0;
    expect_beat(8'h33, 0, 3'b001, 1'b0);
    tick(); tick(); tick(); expect_idle(1'b1);
    tick();

    // Randomized traffic, checked every cycle against the model.
    repeat (3000) begin
      apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), 24'($urandom));
      Rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    Rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, '0);
    repeat (6) tick();

    // Single-row instance.
    h1_in = 8'h5A; h1_start = 1'b1;
    tick(); h1_start = 1'b0;
    check_output("h1_valid", 32'(h1_valid), 32'd1);
    check_output("h1_busy", 32'(h1_busy), 32'd1);
    check_output("h1_data", 32'(h1_data), 32'h5A);
    check_output("h1_idx", 32'(h1_idx), 32'd0);
    check_output("h1_cs", 32'(h1_cs), 32'd1);
    check_output("h1_last", 32'(h1_last), 32'd1);
    check_output("h1_done_early", 32'(h1_done), 32'd0);
    tick();
    check_output("h1_valid_after", 32'(h1_valid), 32'd0);
    check_output("h1_done", 32'(h1_done), 32'd1);
    tick();
    check_output("h1_done_clear", 32'(h1_done), 32'd0);

    cmp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
